// File: rtl/ieee_sqrt_stream.sv
// Valid/ready streaming shell for a fixed-latency IEEE square-root core.
// Tracks in-flight ops in a valid/tag pipeline and buffers results in a credit-protected FIFO.
module ieee_sqrt_stream #(
   parameter int DataWidth = 32,
   parameter int Latency   = 2,
   parameter int TagWidth  = 4,
   parameter int FifoDepth = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_data_i,
   input  logic [TagWidth-1:0]  in_tag_i,
   output logic [DataWidth-1:0] core_x_o,
   input  logic [DataWidth-1:0] core_result_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_data_o,
   output logic [TagWidth-1:0]  out_tag_o,
   output logic                 out_nv_o,
   output logic                 busy_o
);

   localparam int ExpW = (DataWidth == 64) ? 11 : 8;
   localparam int ManW = DataWidth - 1 - ExpW;
   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntW = $clog2(FifoDepth + 1);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(FifoDepth - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(FifoDepth);

   function automatic logic is_nan(input logic [DataWidth-1:0] v);
      return (&v[DataWidth-2 -: ExpW]) & (|v[ManW-1:0]);
   endfunction

   logic                accept;
   logic                pop;
   logic                cap_vld;
   logic [TagWidth-1:0] cap_tag;
   logic                cap_op_nan;

   logic [CntW-1:0]     credits_q, credits_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;

   logic [DataWidth-1:0] fifo_data_q [FifoDepth];
   logic [DataWidth-1:0] fifo_data_d [FifoDepth];
   logic [TagWidth-1:0]  fifo_tag_q  [FifoDepth];
   logic [TagWidth-1:0]  fifo_tag_d  [FifoDepth];
   logic [FifoDepth-1:0] fifo_nv_q, fifo_nv_d;

   // Credits cover both in-flight ops and buffered results, so a free credit
   // guarantees a FIFO slot when the op reaches the pipeline tail.
   assign in_ready_o  = (credits_q != '0) & ~rst_i;
   assign accept      = in_valid_i & in_ready_o;
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o & out_ready_i;
   assign busy_o      = (credits_q != CntFull);
   assign core_x_o    = in_data_i;

   assign out_data_o  = fifo_data_q[rd_ptr_q];
   assign out_tag_o   = fifo_tag_q[rd_ptr_q];
   assign out_nv_o    = fifo_nv_q[rd_ptr_q];

   if (Latency == 0) begin : g_wire
      assign cap_vld    = accept;
      assign cap_tag    = in_tag_i;
      assign cap_op_nan = is_nan(in_data_i);
   end else begin : g_pipe
      logic [Latency-1:0]  vld_q, vld_d;
      logic [Latency-1:0]  nan_q, nan_d;
      logic [TagWidth-1:0] tag_q [Latency];
      logic [TagWidth-1:0] tag_d [Latency];

      always_comb begin
         vld_d[0] = accept;
         nan_d[0] = is_nan(in_data_i);
         tag_d[0] = in_tag_i;
         for (int i = 1; i < Latency; i++) begin
            vld_d[i] = vld_q[i-1];
            nan_d[i] = nan_q[i-1];
            tag_d[i] = tag_q[i-1];
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            vld_q <= '0;
         end else begin
            vld_q <= vld_d;
         end
         nan_q <= nan_d;
         tag_q <= tag_d;
      end

      assign cap_vld    = vld_q[Latency-1];
      assign cap_tag    = tag_q[Latency-1];
      assign cap_op_nan = nan_q[Latency-1];
   end

   always_comb begin
      credits_d   = credits_q - CntW'(accept) + CntW'(pop);
      count_d     = count_q + CntW'(cap_vld) - CntW'(pop);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_data_d = fifo_data_q;
      fifo_tag_d  = fifo_tag_q;
      fifo_nv_d   = fifo_nv_q;
      if (cap_vld) begin
         fifo_data_d[wr_ptr_q] = core_result_i;
         fifo_tag_d[wr_ptr_q]  = cap_tag;
         fifo_nv_d[wr_ptr_q]   = is_nan(core_result_i) & ~cap_op_nan;
         wr_ptr_d              = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         credits_q <= CntFull;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         credits_q <= credits_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Result storage is deliberately left unreset; count_q gates its visibility.
   always_ff @(posedge clk_i) begin
      fifo_data_q <= fifo_data_d;
      fifo_tag_q  <= fifo_tag_d;
      fifo_nv_q   <= fifo_nv_d;
   end

   a_credit_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(accept && !pop && credits_q == '0));
   a_credit_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(pop && !accept && credits_q == CntFull));
   a_credit_range: assert property (@(posedge clk_i) disable iff (rst_i)
      credits_q <= CntFull);

endmodule

// File: tb/tb_ieee_sqrt_stream.sv
// Scoreboard bench for ieee_sqrt_stream with a behavioural 2-cycle sqrt core.
// Issue monitor pushes expected results on accept; output monitor pops and compares on handshake.
module tb_ieee_sqrt_stream;

   localparam int FD = 3;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_data_i;
   logic [3:0]  in_tag_i;
   logic [31:0] core_x_o;
   logic [31:0] core_result_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_data_o;
   logic [3:0]  out_tag_o;
   logic        out_nv_o;
   logic        busy_o;

   always #5 clk = ~clk;

   ieee_sqrt_stream #(
      .DataWidth(32), .Latency(2), .TagWidth(4), .FifoDepth(FD)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_data_i(in_data_i), .in_tag_i(in_tag_i),
      .core_x_o(core_x_o), .core_result_i(core_result_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_tag_o(out_tag_o),
      .out_nv_o(out_nv_o), .busy_o(busy_o)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        nv;
   } exp_t;

   exp_t        sb_q[$];
   int          pop_cyc_q[$];
   logic [31:0] cur_exp_data;
   logic        cur_exp_nv;
   int          n_checks = 0;
   int          n_pass = 0;
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   int          cyc = 0;
   bit          rand_en = 1'b0;
   bit          sb_over = 1'b0;

   task automatic check(input bit ok, input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // single-precision encoding of a non-negative integer below 2^24
   function automatic logic [31:0] k2f(input int k);
      int          e;
      logic [31:0] m;
      if (k == 0) return 32'h0;
      e = 0;
      for (int i = 0; i < 31; i++) if (k[i]) e = i;
      m = 32'(k) << (23 - e);
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction

   // core model: exact for perfect squares of 0..255, quiets NaNs, NaN for negatives
   function automatic logic [31:0] core_f(input logic [31:0] x);
      int lo, hi, mid;
      logic [31:0] v;
      if (x[30:23] == 8'hFF && x[22:0] != 23'h0) return x | 32'h0040_0000;
      if (x[30:0] == 31'h0) return x;
      if (x[31]) return 32'h7FC0_0000;
      if (x == 32'h7F80_0000) return x;
      lo = 0;
      hi = 255;
      while (lo <= hi) begin
         mid = (lo + hi) / 2;
         v = k2f(mid * mid);
         if (v == x) return k2f(mid);
         if (v < x) lo = mid + 1;
         else hi = mid - 1;
      end
      return 32'h7FC0_0000;
   endfunction

   logic [31:0] cp0, cp1;
   always @(posedge clk) begin
      cp0 <= core_f(core_x_o);
      cp1 <= cp0;
   end
   assign core_result_i = cp1;

   always @(posedge clk) begin
      cyc++;
      if (sb_q.size() > FD) sb_over = 1'b1;
   end

   always @(negedge clk) begin
      if (!rst_i && in_valid_i && in_ready_o) begin
         sb_q.push_back('{data: cur_exp_data, tag: in_tag_i, nv: cur_exp_nv});
         acc_cnt++;
      end
   end

   exp_t        e_pop;
   bit          hold_vld = 1'b0;
   logic [36:0] hold_val;
   always @(negedge clk) begin
      if (rst_i) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld && out_valid_o)
            check({out_data_o, out_tag_o, out_nv_o} == hold_val, "hold_stable",
                  64'({out_data_o, out_tag_o, out_nv_o}), 64'(hold_val));
         if (out_valid_o && out_ready_i) begin
            pop_cnt++;
            pop_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
               check(1'b0, "unexpected_out", 64'(out_data_o), 64'h0);
            end else begin
               e_pop = sb_q.pop_front();
               check({out_data_o, out_tag_o, out_nv_o} == e_pop, "result{data,tag,nv}",
                     64'({out_data_o, out_tag_o, out_nv_o}), 64'(e_pop));
            end
            hold_vld = 1'b0;
         end else if (out_valid_o) begin
            hold_vld = 1'b1;
            hold_val = {out_data_o, out_tag_o, out_nv_o};
         end else begin
            hold_vld = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_en) out_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_accept(output int stalls);
      stalls = 0;
      forever begin
         @(negedge clk);
         if (in_ready_o) break;
         stalls++;
         if (stalls > 400) begin
            check(1'b0, "accept_timeout", 64'(stalls), 64'd0);
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic set_op(input logic [31:0] d, input logic [3:0] t,
                         input logic [31:0] ed, input logic env);
      in_valid_i   = 1'b1;
      in_data_i    = d;
      in_tag_i     = t;
      cur_exp_data = ed;
      cur_exp_nv   = env;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] t,
                       input logic [31:0] ed, input logic env, output int stalls);
      set_op(d, t, ed, env);
      wait_accept(stalls);
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      tick();
      check(sb_q.size() == 0, "drain", 64'(sb_q.size()), 64'd0);
      check(busy_o == 1'b0, "busy_idle", 64'(busy_o), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, tot, a0, n, k, r, p0;
      logic [31:0] d, ed;
      logic env;

      rst_i        = 1'b1;
      in_valid_i   = 1'b0;
      in_data_i    = '0;
      in_tag_i     = '0;
      out_ready_i  = 1'b1;
      cur_exp_data = '0;
      cur_exp_nv   = 1'b0;
      repeat (3) tick();
      check(in_ready_o == 1'b0, "ready_in_reset", 64'(in_ready_o), 64'd0);
      rst_i = 1'b0;
      #1;
      check(out_valid_o == 1'b0, "reset_out_valid", 64'(out_valid_o), 64'd0);
      check(busy_o == 1'b0, "reset_busy", 64'(busy_o), 64'd0);
      check(in_ready_o == 1'b1, "reset_ready", 64'(in_ready_o), 64'd1);
      tick();

      // directed vectors, out_ready held high
      send(32'h4080_0000, 4'd5, 32'h4000_0000, 1'b0, st);
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (out_valid_o) break;
      end
      check(n == 3, "latency_cycles", 64'(n), 64'd3);
      tick();
      send(32'hBF80_0000, 4'd6, 32'h7FC0_0000, 1'b1, st);
      send(32'h7FC0_0000, 4'd7, 32'h7FC0_0000, 1'b0, st);
      send(32'h7F80_0001, 4'd8, 32'h7FC0_0001, 1'b0, st);
      send(32'h7F80_0000, 4'd9, 32'h7F80_0000, 1'b0, st);
      send(32'h8000_0000, 4'd10, 32'h8000_0000, 1'b0, st);
      send(32'h4110_0000, 4'd11, 32'h4040_0000, 1'b0, st);
      send(32'h4180_0000, 4'd12, 32'h4080_0000, 1'b0, st);
      drain();

      // backpressure: credits cap acceptance at FifoDepth
      out_ready_i = 1'b0;
      a0 = acc_cnt;
      for (int t = 0; t < 3; t++) send(k2f((t + 2) * (t + 2)), 4'(t), k2f(t + 2), 1'b0, st);
      set_op(k2f(25), 4'd3, k2f(5), 1'b0);
      repeat (8) tick();
      check(acc_cnt - a0 == 3, "bp_accept_count", 64'(acc_cnt - a0), 64'd3);
      check(in_ready_o == 1'b0, "bp_ready_low", 64'(in_ready_o), 64'd0);
      out_ready_i = 1'b1;
      @(negedge clk);
      check(in_ready_o == 1'b0, "bp_no_bypass", 64'(in_ready_o), 64'd0);
      wait_accept(st);
      check(st == 0, "bp_resume_after_pop", 64'(st), 64'd0);
      in_valid_i = 1'b0;
      for (int t = 4; t < 10; t++) send(k2f((t + 2) * (t + 2)), 4'(t), k2f(t + 2), 1'b0, st);
      drain();
      check(acc_cnt - a0 == 10, "bp_total_accepts", 64'(acc_cnt - a0), 64'd10);

      // 32 back-to-back: three accepts per four-cycle credit round trip
      pop_cyc_q.delete();
      tot = 0;
      for (int t = 0; t < 32; t++) begin
         send(k2f((t + 10) * (t + 10)), 4'(t), k2f(t + 10), 1'b0, st);
         tot += st;
      end
      drain();
      check(tot == 10, "stream_stall_cycles", 64'(tot), 64'd10);
      check(pop_cyc_q.size() == 32, "stream_result_count", 64'(pop_cyc_q.size()), 64'd32);

      // random backpressure, mixed operand classes
      p0 = pop_cnt;
      rand_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         r = $urandom_range(0, 9);
         k = $urandom_range(1, 255);
         if (r < 8) begin
            k = $urandom_range(0, 255);
            d = k2f(k * k);
            ed = k2f(k);
            env = 1'b0;
         end else if (r == 8) begin
            d = 32'h8000_0000 | k2f(k * k);
            ed = 32'h7FC0_0000;
            env = 1'b1;
         end else begin
            d = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 23'h7F_FFFF))};
            ed = d | 32'h0040_0000;
            env = 1'b0;
         end
         send(d, 4'(i), ed, env, st);
      end
      rand_en = 1'b0;
      out_ready_i = 1'b1;
      drain();
      check(pop_cnt - p0 == 1000, "random_no_loss", 64'(pop_cnt - p0), 64'd1000);
      check(sb_over == 1'b0, "outstanding_bound", 64'(sb_over), 64'd0);

      // reset with ops in flight and results buffered
      out_ready_i = 1'b0;
      for (int t = 0; t < 3; t++) send(k2f((t + 5) * (t + 5)), 4'(t), k2f(t + 5), 1'b0, st);
      tick();
      check(busy_o == 1'b1, "busy_before_reset", 64'(busy_o), 64'd1);
      rst_i = 1'b1;
      sb_q.delete();
      #1;
      check(in_ready_o == 1'b0, "ready_during_reset", 64'(in_ready_o), 64'd0);
      tick();
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      #1;
      check(dut.credits_q == 2'd3, "credits_after_reset", 64'(dut.credits_q), 64'd3);
      check(busy_o == 1'b0, "busy_after_reset", 64'(busy_o), 64'd0);
      n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid_o) n++;
      end
      check(n == 0, "no_out_after_reset", 64'(n), 64'd0);
      tick();
      p0 = pop_cnt;
      send(k2f(144), 4'd13, k2f(12), 1'b0, st);
      drain();
      check(pop_cnt - p0 == 1, "post_reset_result", 64'(pop_cnt - p0), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
